button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/calc_input_pkg.sv | 23 ++
 rtl/button_channel.sv | 112 +++++++++++
 rtl/button_conditioner.sv | 72 +++++++
 3 files changed

// File: rtl/calc_input_pkg.sv
// Shared constants, counter widths and parameter checks for the button conditioner.
package calc_input_pkg;

  // Stability counters must hold DEBOUNCE_MS up to 255.
  localparam int DEBOUNCE_MAX = 255;
  localparam int STAB_W = $clog2(DEBOUNCE_MAX + 1);

  function automatic int MS_CYCLES(input int freq);
    return freq / 1000;
  endfunction

  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

  function automatic bit params_legal(input int width, input int freq, input int debounce_ms,
                                      input int active_low, input int hold_ms, input int repeat_ms);
    return (width >= 1) && (freq >= 1000) && (debounce_ms >= 1) &&
           (debounce_ms <= DEBOUNCE_MAX) && (active_low == 0 || active_low == 1) &&
           (hold_ms >= 1) && (repeat_ms >= 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced button channel: stability counter, level, edge pulses and,
// with BUTTON_AUTOREPEAT_EN defined, the hold/auto-repeat counter.
module button_channel
  import calc_input_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic ms_tick_i,
  input  logic sample_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_MS - 1);

  logic [STAB_W-1:0] stab_q, stab_d;
  logic level_q, level_d;
  logic press_q, release_q;
  logic toggle;

  always_comb begin
    stab_d  = stab_q;
    level_d = level_q;
    toggle  = 1'b0;
    if (sample_i == level_q) begin
      stab_d = '0;
    end else if (ms_tick_i) begin
      if (stab_q == STAB_LAST) begin
        toggle  = 1'b1;
        level_d = ~level_q;
        stab_d  = '0;
      end else if (stab_q != '1) begin
        stab_d = stab_q + STAB_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stab_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      stab_q    <= stab_d;
      level_q   <= level_d;
      press_q   <= toggle & ~level_q;
      release_q <= toggle & level_q;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int HOLD_W = cnt_width((HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS);
  localparam logic [HOLD_W-1:0] HOLD_T = HOLD_W'(HOLD_MS);
  localparam logic [HOLD_W-1:0] REP_T  = HOLD_W'(REPEAT_MS);

  logic [HOLD_W-1:0] hold_q, hold_d, target;
  logic rep_mode_q, rep_mode_d;
  logic repeat_q, repeat_d;

  // First target is the hold delay; after the first repeat the count restarts
  // against the repeat interval, so the counter never exceeds its target.
  always_comb begin
    hold_d     = hold_q;
    rep_mode_d = rep_mode_q;
    repeat_d   = 1'b0;
    target     = rep_mode_q ? REP_T : HOLD_T;
    if (!level_q || toggle) begin
      hold_d     = '0;
      rep_mode_d = 1'b0;
    end else if (ms_tick_i) begin
      if (hold_q + HOLD_W'(1) == target) begin
        repeat_d   = 1'b1;
        hold_d     = '0;
        rep_mode_d = 1'b1;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      rep_mode_q <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      rep_mode_q <= rep_mode_d;
      repeat_q   <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button debouncer with press/release pulses; auto-repeat is
// built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner
  import calc_input_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int FREQ        = 50000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int ACTIVE_LOW  = 1,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic [WIDTH-1:0] repeat_o
);

  localparam int MS_CYC = MS_CYCLES(FREQ);
  localparam int PRE_W  = cnt_width(MS_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYC - 1);
  localparam logic [WIDTH-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  if (!params_legal(WIDTH, FREQ, DEBOUNCE_MS, ACTIVE_LOW, HOLD_MS, REPEAT_MS)) begin : g_bad_params
    $error("button_conditioner: illegal parameter combination");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q, sample;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic ms_tick;

  // Synchronisers idle at the released level so reset never looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
      pre_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      pre_q   <= pre_d;
    end
  end

  assign sample  = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign ms_tick = (pre_q == PRE_LAST);
  assign pre_d   = ms_tick ? '0 : pre_q + PRE_W'(1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
`ifdef BUTTON_AUTOREPEAT_EN
      ,
      .HOLD_MS    (HOLD_MS),
      .REPEAT_MS  (REPEAT_MS)
`endif
    ) u_channel (
      .clock    (clock),
      .reset    (reset),
      .ms_tick_i(ms_tick),
      .sample_i (sample[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .repeat_o (repeat_o[i])
    );
  end

endmodule
